clue_encoder: RTL and testbench

Converts a solved nonogram board into the run-length clue byte stream that `parser` consumes, and drives `uart_tx` one byte at a time. It sits between `parallel_solver` output and `uart_tx` as an alternative to `assembler`. Its uses are hardware loopback, where the solver's output is re-encoded as a puzzle, and self-checking of boards received over UART.

---
 rtl/clue_encoder_pkg.sv | 29 ++
 rtl/clue_encoder_if.sv | 32 +++
 rtl/line_run_extractor.sv | 105 ++++++++++
 rtl/clue_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_clue_encoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/clue_encoder_pkg.sv
// Shared nonogram definitions used by the clue encoder.
//   MAX_ROWS / MAX_COLS : largest supported board
//   RUN_SLOTS           : run buffer depth (ceil(11/2) runs per line at most)
//   END_BYTE            : stream terminator, never a legal count or length
//   enc_state_e         : clue encoder FSM states
//   cell_index(r, c)    : bit position of cell (r,c) in the flattened board
package nonogram_pkg;

    localparam int unsigned MAX_ROWS  = 11;
    localparam int unsigned MAX_COLS  = 11;
    localparam int unsigned RUN_SLOTS = 6;
    localparam logic [7:0]  END_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StScan,
        StEmitCnt,
        StEmitRun,
        StEnd,
        StFin,
        StWait
    } enc_state_e;

    function automatic int unsigned cell_index(input int unsigned r, input int unsigned c);
        return r * MAX_COLS + c;
    endfunction

endpackage

// File: rtl/clue_encoder_if.sv
// Bundle between the solver / uart_tx side and clue_encoder.
//   valid_in, solution, m, n : start request and the board to encode
//   transmit_done            : uart_tx finished the current byte
//   send, byte_out           : byte strobe towards uart_tx
//   done, busy               : stream status
// slave is the encoder's view, master the surrounding logic's view.
interface clue_encoder_if #(
    parameter int unsigned MAX_ROWS = nonogram_pkg::MAX_ROWS,
    parameter int unsigned MAX_COLS = nonogram_pkg::MAX_COLS
) ();

    logic                         valid_in;
    logic [MAX_ROWS*MAX_COLS-1:0] solution;
    logic [$clog2(MAX_ROWS):0]    m;
    logic [$clog2(MAX_COLS):0]    n;
    logic                         transmit_done;
    logic                         send;
    logic [7:0]                   byte_out;
    logic                         done;
    logic                         busy;

    modport slave (
        input  valid_in, solution, m, n, transmit_done,
        output send, byte_out, done, busy
    );

    modport master (
        output valid_in, solution, m, n, transmit_done,
        input  send, byte_out, done, busy
    );

endinterface

// File: rtl/line_run_extractor.sv
// Run-length extractor for one board line, fed one cell per cycle.
//   clk_50mhz, rst : clock, synchronous active-high reset
//   start          : first cycle of a line; bit_in already carries cell 0
//   line_len       : cells in this line
//   bit_in         : current cell, 1 = filled
//   runs_valid     : results ready; held until the next start
//   run_count      : number of runs found
//   runs           : run lengths in index order
module line_run_extractor
    import nonogram_pkg::*;
#(
    parameter int unsigned LenW = 4
) (
    input  logic            clk_50mhz,
    input  logic            rst,
    input  logic            start,
    input  logic [LenW-1:0] line_len,
    input  logic            bit_in,
    output logic            runs_valid,
    output logic [3:0]      run_count,
    output logic [3:0]      runs [RUN_SLOTS]
);

    logic            active_q, active_d;
    logic            valid_q, valid_d;
    logic [LenW-1:0] pos_q, pos_d;
    logic [3:0]      cur_q, cur_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      runs_q [RUN_SLOTS];
    logic [3:0]      runs_d [RUN_SLOTS];

    logic [LenW-1:0] pos_b;
    logic [3:0]      cur_b;
    logic [2:0]      cnt_b;
    logic            last;

    always_comb begin
        active_d = active_q;
        valid_d  = valid_q;
        pos_d    = pos_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        runs_d   = runs_q;
        // On start the previous line's state is discarded in the same cycle.
        pos_b    = start ? '0 : pos_q;
        cur_b    = start ? '0 : cur_q;
        cnt_b    = start ? '0 : cnt_q;
        last     = (pos_b == line_len - 1'b1);

        if (start) begin
            for (int i = 0; i < RUN_SLOTS; i++) begin
                runs_d[i] = '0;
            end
            cnt_d    = '0;
            cur_d    = '0;
            pos_d    = '0;
            active_d = 1'b0;
            valid_d  = (line_len == '0);
        end

        if ((start || active_q) && line_len != '0) begin
            cur_d = bit_in ? cur_b + 4'd1 : 4'd0;
            // A run closes on a 1->0 edge or when the line ends while filled.
            if (!bit_in && cur_b != 4'd0) begin
                if (cnt_b < 3'(RUN_SLOTS)) begin
                    runs_d[cnt_b] = cur_b;
                    cnt_d         = cnt_b + 3'd1;
                end
            end else if (bit_in && last) begin
                if (cnt_b < 3'(RUN_SLOTS)) begin
                    runs_d[cnt_b] = cur_b + 4'd1;
                    cnt_d         = cnt_b + 3'd1;
                end
            end
            pos_d    = pos_b + 1'b1;
            active_d = !last;
            valid_d  = last;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            pos_q    <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RUN_SLOTS; i++) begin
                runs_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            valid_q  <= valid_d;
            pos_q    <= pos_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            runs_q   <= runs_d;
        end
    end

    assign runs_valid = valid_q;
    assign run_count  = {1'b0, cnt_q};
    assign runs       = runs_q;

endmodule

// File: rtl/clue_encoder.sv
// Re-encodes a solved board as the parser's clue byte stream:
//   m, n, per-row clues, per-column clues, 0xFF.
// Each line clue is its run count followed by the run lengths.
//   clk_50mhz, rst : clock, synchronous active-high reset
//   bus            : start request / board in, uart_tx byte handshake out
// MAX_ROWS / MAX_COLS must match nonogram_pkg, which fixes cell_index().
module clue_encoder #(
    parameter int unsigned MAX_ROWS = nonogram_pkg::MAX_ROWS,
    parameter int unsigned MAX_COLS = nonogram_pkg::MAX_COLS
) (
    input logic           clk_50mhz,
    input logic           rst,
    clue_encoder_if.slave bus
);

    import nonogram_pkg::*;

    localparam int unsigned MW   = $clog2(MAX_ROWS) + 1;
    localparam int unsigned NW   = $clog2(MAX_COLS) + 1;
    localparam int unsigned LenW = $clog2((MAX_ROWS > MAX_COLS ? MAX_ROWS : MAX_COLS) + 1);
    localparam int unsigned IdxW = $clog2(MAX_ROWS * MAX_COLS);

    enc_state_e                   state_q, state_d, ret_q, ret_d;
    logic [MAX_ROWS*MAX_COLS-1:0] board_q, board_d;
    logic [MW-1:0]                m_q, m_d;
    logic [NW-1:0]                n_q, n_d;
    logic                         hdr_n_q, hdr_n_d;
    logic                         col_q, col_d;
    logic [LenW-1:0]              line_q, line_d;
    logic [LenW-1:0]              pos_q, pos_d;
    logic                         started_q, started_d;
    logic [2:0]                   run_idx_q, run_idx_d;
    logic [7:0]                   byte_q;

    logic [LenW-1:0] line_len, num_lines, cell_r, cell_c;
    logic [IdxW-1:0] cell_idx;
    logic            last_line, ext_start, ext_bit;
    logic            runs_valid;
    logic [3:0]      run_count;
    logic [3:0]      runs [RUN_SLOTS];
    logic            send_c, done_c;
    logic [7:0]      cur_byte;
    enc_state_e      nl_ret;

    // Rows are n cells long and m in number; columns the other way round.
    assign line_len  = col_q ? LenW'(m_q) : LenW'(n_q);
    assign num_lines = col_q ? LenW'(n_q) : LenW'(m_q);
    assign last_line = (line_q == num_lines - 1'b1);
    assign nl_ret    = (col_q && last_line) ? StEnd : StScan;
    assign cell_r    = col_q ? pos_q : line_q;
    assign cell_c    = col_q ? line_q : pos_q;
    assign cell_idx  = IdxW'(cell_index(int'(cell_r), int'(cell_c)));
    assign ext_bit   = board_q[cell_idx];

    line_run_extractor #(
        .LenW(LenW)
    ) u_extractor (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .start     (ext_start),
        .line_len  (line_len),
        .bit_in    (ext_bit),
        .runs_valid(runs_valid),
        .run_count (run_count),
        .runs      (runs)
    );

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        board_d   = board_q;
        m_d       = m_q;
        n_d       = n_q;
        hdr_n_d   = hdr_n_q;
        col_d     = col_q;
        line_d    = line_q;
        pos_d     = pos_q;
        started_d = started_q;
        run_idx_d = run_idx_q;
        send_c    = 1'b0;
        done_c    = 1'b0;
        cur_byte  = byte_q;
        ext_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    board_d = bus.solution;
                    m_d     = (bus.m > MW'(MAX_ROWS)) ? MW'(MAX_ROWS) : bus.m;
                    n_d     = (bus.n > NW'(MAX_COLS)) ? NW'(MAX_COLS) : bus.n;
                    hdr_n_d = 1'b0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                send_c  = 1'b1;
                state_d = StWait;
                if (!hdr_n_q) begin
                    cur_byte = 8'(m_q);
                    hdr_n_d  = 1'b1;
                    ret_d    = StHdr;
                end else begin
                    cur_byte  = 8'(n_q);
                    ret_d     = (m_q == '0 || n_q == '0) ? StEnd : StScan;
                    col_d     = 1'b0;
                    line_d    = '0;
                    pos_d     = '0;
                    started_d = 1'b0;
                end
            end
            StScan: begin
                // The first scan cycle presents cell 0 together with start.
                ext_start = !started_q;
                started_d = 1'b1;
                if (pos_q < line_len - 1'b1) begin
                    pos_d = pos_q + 1'b1;
                end
                if (started_q && runs_valid) begin
                    state_d = StEmitCnt;
                end
            end
            StEmitCnt: begin
                send_c    = 1'b1;
                cur_byte  = 8'(run_count);
                run_idx_d = '0;
                state_d   = StWait;
                if (run_count == 4'd0) begin
                    ret_d     = nl_ret;
                    col_d     = col_q | last_line;
                    line_d    = last_line ? '0 : line_q + 1'b1;
                    pos_d     = '0;
                    started_d = 1'b0;
                end else begin
                    ret_d = StEmitRun;
                end
            end
            StEmitRun: begin
                send_c    = 1'b1;
                cur_byte  = 8'(runs[run_idx_q]);
                run_idx_d = run_idx_q + 3'd1;
                state_d   = StWait;
                if ({1'b0, run_idx_q} + 4'd1 == run_count) begin
                    ret_d     = nl_ret;
                    col_d     = col_q | last_line;
                    line_d    = last_line ? '0 : line_q + 1'b1;
                    pos_d     = '0;
                    started_d = 1'b0;
                end else begin
                    ret_d = StEmitRun;
                end
            end
            StEnd: begin
                send_c   = 1'b1;
                cur_byte = END_BYTE;
                ret_d    = StFin;
                state_d  = StWait;
            end
            StFin: begin
                done_c  = 1'b1;
                state_d = StIdle;
            end
            StWait: begin
                if (bus.transmit_done) begin
                    state_d = ret_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q   <= StIdle;
            ret_q     <= StIdle;
            board_q   <= '0;
            m_q       <= '0;
            n_q       <= '0;
            hdr_n_q   <= 1'b0;
            col_q     <= 1'b0;
            line_q    <= '0;
            pos_q     <= '0;
            started_q <= 1'b0;
            run_idx_q <= '0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            board_q   <= board_d;
            m_q       <= m_d;
            n_q       <= n_d;
            hdr_n_q   <= hdr_n_d;
            col_q     <= col_d;
            line_q    <= line_d;
            pos_q     <= pos_d;
            started_q <= started_d;
            run_idx_q <= run_idx_d;
            byte_q    <= cur_byte;
        end
    end

    // byte_out keeps the last strobed byte between sends.
    assign bus.send     = send_c;
    assign bus.byte_out = cur_byte;
    assign bus.done     = done_c;
    assign bus.busy     = (state_q != StIdle) && (state_q != StFin);

endmodule

// File: tb/tb_clue_encoder.sv
// Scoreboard bench for clue_encoder with a uart_tx model that answers each
// send with transmit_done a fixed number of cycles later.
module tb_clue_encoder;

    localparam int R = 11;
    localparam int C = 11;

    typedef logic [7:0] bytes_t [$];

    logic clk_50mhz = 1'b0;
    logic rst       = 1'b1;

    clue_encoder_if bus ();

    clue_encoder u_dut (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .bus      (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    logic [7:0] exp_q [$];
    int n_checks  = 0;
    int n_fail    = 0;
    int send_cnt  = 0;
    int done_cnt  = 0;
    int uart_lat  = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [R*C-1:0] mk3(input logic [10:0] r0, input logic [10:0] r1,
                                           input logic [10:0] r2);
        logic [R*C-1:0] b;
        b         = '0;
        b[0 +: C]  = r0;
        b[C +: C]  = r1;
        b[2*C +: C] = r2;
        return b;
    endfunction

    // uart_tx model
    initial begin
        bus.transmit_done = 1'b0;
        forever begin
            @(negedge clk_50mhz);
            if (!rst && bus.send) begin
                repeat (uart_lat) @(posedge clk_50mhz);
                #1 bus.transmit_done = 1'b1;
                @(posedge clk_50mhz);
                #1 bus.transmit_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe, counts done pulses.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_50mhz);
            if (!rst && bus.send) begin
                send_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_send: got %02h, expected no byte", bus.byte_out);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_out", 32'(bus.byte_out), 32'(e));
                end
            end
            if (!rst && bus.done) begin
                done_cnt++;
                check("busy_low_at_done", 32'(bus.busy), 32'd0);
                check("stream_complete_at_done", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    task automatic start_stream(input logic [R*C-1:0] b, input logic [4:0] mm,
                                input logic [4:0] nn);
        @(posedge clk_50mhz);
        #1;
        bus.solution = b;
        bus.m        = mm;
        bus.n        = nn;
        bus.valid_in = 1'b1;
        @(posedge clk_50mhz);
        #1 bus.valid_in = 1'b0;
        @(negedge clk_50mhz);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("send_after_start", 32'(bus.send), 32'd1);
    endtask

    task automatic run_case(input string name, input logic [R*C-1:0] b, input logic [4:0] mm,
                            input logic [4:0] nn, input bytes_t e, input int budget,
                            input int repulse);
        int d0;
        int cyc;
        foreach (e[i]) exp_q.push_back(e[i]);
        d0 = done_cnt;
        start_stream(b, mm, nn);
        cyc = 0;
        while (done_cnt == d0 && cyc < budget) begin
            @(posedge clk_50mhz);
            #1;
            cyc++;
            if (repulse != 0 && cyc == repulse) begin
                bus.valid_in = 1'b1;
                bus.solution = '0;
                bus.m        = 5'd2;
                bus.n        = 5'd2;
            end else begin
                bus.valid_in = 1'b0;
            end
        end
        repeat (50) @(posedge clk_50mhz);
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_idle_after"}, 32'(bus.busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bytes_t e;
        int     base;
        int     cyc;
        bus.valid_in = 1'b0;
        bus.solution = '0;
        bus.m        = '0;
        bus.n        = '0;
        repeat (3) @(posedge clk_50mhz);
        #1 rst = 1'b0;
        @(negedge clk_50mhz);
        check("reset_send", 32'(bus.send), 32'd0);
        check("reset_byte", 32'(bus.byte_out), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        // 3x3 all ones
        e = '{8'h03, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03,
              8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'hFF};
        base = send_cnt;
        run_case("ones3", mk3(11'h7, 11'h7, 11'h7), 5'd3, 5'd3, e, 3000, 0);
        check("ones3_send_count", 32'(send_cnt - base), 32'd15);

        // 3x3 checkerboard
        e = '{8'h03, 8'h03, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01,
              8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'hFF};
        run_case("checker3", mk3(11'b101, 11'b010, 11'b101), 5'd3, 5'd3, e, 3000, 0);

        // 2x2 empty, filled cells outside the active area must be ignored
        e = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        run_case("empty2", mk3(11'b100, 11'b100, 11'h7FF), 5'd2, 5'd2, e, 3000, 0);

        // 11x11, row 0 alternating
        e = '{8'h0B, 8'h0B, 8'h06, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        for (int i = 0; i < 10; i++) e.push_back(8'h00);
        for (int c = 0; c < 11; c++) begin
            if (c % 2 == 0) begin
                e.push_back(8'h01);
                e.push_back(8'h01);
            end else begin
                e.push_back(8'h00);
            end
        end
        e.push_back(8'hFF);
        run_case("alt11", mk3(11'b10101010101, 11'h0, 11'h0), 5'd11, 5'd11, e, 5000, 0);

        // Zero rows: header and terminator only
        e = '{8'h00, 8'h03, 8'hFF};
        run_case("zero_m", mk3(11'h7, 11'h7, 11'h7), 5'd0, 5'd3, e, 1000, 0);

        // m saturates to 11
        e = '{8'h0B, 8'h02};
        for (int i = 0; i < 13; i++) e.push_back(8'h00);
        e.push_back(8'hFF);
        run_case("sat_m", '0, 5'd20, 5'd2, e, 3000, 0);

        // Slow uart, start re-pulsed mid-stream
        uart_lat = 1000;
        e = '{8'h03, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03,
              8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'hFF};
        run_case("repulse", mk3(11'h7, 11'h7, 11'h7), 5'd3, 5'd3, e, 20000, 2500);
        uart_lat = 5;
        repeat (20) @(posedge clk_50mhz);

        // Reset after the 4th byte, then restart
        e = '{8'h03, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03,
              8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'hFF};
        foreach (e[i]) exp_q.push_back(e[i]);
        base = send_cnt;
        start_stream(mk3(11'h7, 11'h7, 11'h7), 5'd3, 5'd3);
        cyc = 0;
        while (send_cnt < base + 4 && cyc < 500) begin
            @(negedge clk_50mhz);
            cyc++;
        end
        check("rst_fourth_send_seen", 32'(send_cnt - base), 32'd4);
        @(posedge clk_50mhz);
        #1 rst = 1'b1;
        @(posedge clk_50mhz);
        #1 rst = 1'b0;
        @(negedge clk_50mhz);
        check("midrst_send", 32'(bus.send), 32'd0);
        check("midrst_byte", 32'(bus.byte_out), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        repeat (20) @(posedge clk_50mhz);
        run_case("after_rst", mk3(11'h7, 11'h7, 11'h7), 5'd3, 5'd3, e, 3000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
